// File: rtl/display_scan_pkg.sv
// Shared glyph constants and types for the 4-digit multiplexed display scanner.
package display_scan_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    localparam logic [6:0] GLYPH_0 = 7'h40;
    localparam logic [6:0] GLYPH_1 = 7'h79;
    localparam logic [6:0] GLYPH_2 = 7'h24;
    localparam logic [6:0] GLYPH_3 = 7'h30;
    localparam logic [6:0] GLYPH_4 = 7'h19;
    localparam logic [6:0] GLYPH_5 = 7'h12;
    localparam logic [6:0] GLYPH_6 = 7'h02;
    localparam logic [6:0] GLYPH_7 = 7'h78;
    localparam logic [6:0] GLYPH_8 = 7'h00;
    localparam logic [6:0] GLYPH_9 = 7'h10;
    localparam logic [6:0] GLYPH_A = 7'h08;
    localparam logic [6:0] GLYPH_B = 7'h03;
    localparam logic [6:0] GLYPH_C = 7'h46;
    localparam logic [6:0] GLYPH_D = 7'h21;
    localparam logic [6:0] GLYPH_E = 7'h06;
    localparam logic [6:0] GLYPH_F = 7'h0E;

    typedef logic [1:0] slot_t;

    localparam slot_t SLOT_LAST = 2'd3;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
    } disp_t;

    localparam disp_t DISP_OFF = '{an: AN_OFF, seg: SEG_OFF};

    // Active-low one-cold anode pattern for a slot.
    function automatic logic [3:0] an_select(slot_t s);
        return ~(4'b0001 << s);
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low {g,f,e,d,c,b,a} segment decoder.
module hex_to_seg7
    import display_scan_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_OFF;
        unique case (hex_i)
            4'h0: seg_o = GLYPH_0;
            4'h1: seg_o = GLYPH_1;
            4'h2: seg_o = GLYPH_2;
            4'h3: seg_o = GLYPH_3;
            4'h4: seg_o = GLYPH_4;
            4'h5: seg_o = GLYPH_5;
            4'h6: seg_o = GLYPH_6;
            4'h7: seg_o = GLYPH_7;
            4'h8: seg_o = GLYPH_8;
            4'h9: seg_o = GLYPH_9;
            4'hA: seg_o = GLYPH_A;
            4'hB: seg_o = GLYPH_B;
            4'hC: seg_o = GLYPH_C;
            4'hD: seg_o = GLYPH_D;
            4'hE: seg_o = GLYPH_E;
            4'hF: seg_o = GLYPH_F;
        endcase
    end

endmodule

// File: rtl/display_scan.sv
// Four-digit seven-segment scanner with per-digit blanking and whole-display blink.
module display_scan
    import display_scan_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned BLINK_FRAMES = 125
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] digit0,
    input  logic [3:0] digit1,
    input  logic [3:0] digit2,
    input  logic [3:0] digit3,
    input  logic [3:0] blank,
    input  logic       blink_en,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int PS_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(SCAN_DIV - 1);
    localparam logic [7:0]      BL_LAST = 8'(BLINK_FRAMES - 1);

    logic [PS_W-1:0] ps_q, ps_d;
    slot_t           idx_q, idx_d;
    logic [7:0]      bcnt_q, bcnt_d;
    logic            phase_q, phase_d;
    disp_t           out_q, out_d;

    logic       tick;
    logic       frame_end;
    logic       visible;
    logic [3:0] cur_hex;
    logic [6:0] cur_seg;

    assign tick      = (ps_q == PS_LAST);
    assign frame_end = tick && (idx_q == SLOT_LAST);

    always_comb begin
        ps_d  = ps_q + 1'b1;
        idx_d = idx_q;
        if (tick) begin
            ps_d  = '0;
            idx_d = idx_q + 2'd1;
        end
    end

    // Deasserting blink_en always wins over a coincident frame_end.
    always_comb begin
        bcnt_d  = bcnt_q;
        phase_d = phase_q;
        if (!blink_en) begin
            bcnt_d  = '0;
            phase_d = 1'b1;
        end else if (frame_end) begin
            if (bcnt_q == BL_LAST) begin
                bcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                bcnt_d = bcnt_q + 8'd1;
            end
        end
    end

    always_comb begin
        cur_hex = digit0;
        unique case (idx_q)
            2'd0: cur_hex = digit0;
            2'd1: cur_hex = digit1;
            2'd2: cur_hex = digit2;
            2'd3: cur_hex = digit3;
        endcase
    end

    hex_to_seg7 u_dec (
        .hex_i (cur_hex),
        .seg_o (cur_seg)
    );

    // With blink disabled the display is visible even before phase_q catches up.
    assign visible = phase_q | ~blink_en;

    always_comb begin
        out_d = DISP_OFF;
        if (visible && !blank[idx_q]) begin
            out_d.an  = an_select(idx_q);
            out_d.seg = cur_seg;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ps_q    <= '0;
            idx_q   <= '0;
            bcnt_q  <= '0;
            phase_q <= 1'b1;
            out_q   <= DISP_OFF;
        end else begin
            ps_q    <= ps_d;
            idx_q   <= idx_d;
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
            out_q   <= out_d;
        end
    end

    assign an  = out_q.an;
    assign seg = out_q.seg;
    assign dp  = 1'b1;

endmodule

// File: doc/display_scan.md
DISPLAY_SCAN -- requirements
Module: display_scan

Interface
REQ-001 The module SHALL have parameter SCAN_DIV, default 50000: clock cycles per digit slot, legal range 2..2^20.
REQ-002 The module SHALL have parameter BLINK_FRAMES, default 125: full 4-digit scan frames per blink half-period, legal range 1..255.
REQ-003 The module SHALL have input clk, 1 bit: single system clock; all state SHALL be on its rising edge.
REQ-004 The module SHALL have input reset, 1 bit: reset, asynchronous and active-high.
REQ-005 The module SHALL have inputs digit0, digit1, digit2, digit3, each 4 bits: hex value per position; digit0 is the rightmost position.
REQ-006 The module SHALL have input blank, 4 bits: blank[i]=1 SHALL suppress position i.
REQ-007 The module SHALL have input blink_en, 1 bit: 1 SHALL enable whole-display blinking (game-over indication).
REQ-008 The module SHALL have output an, 4 bits: active-low anode selects; an[i] drives position i.
REQ-009 The module SHALL have output seg, 7 bits: active-low segments, ordered {g,f,e,d,c,b,a}.
REQ-010 The module SHALL have output dp, 1 bit: active-low decimal point, held 1 (off).

Function
REQ-011 The prescaler SHALL count 0..SCAN_DIV-1 and wrap; tick SHALL assert for the one cycle in which prescaler = SCAN_DIV-1.
REQ-012 The 2-bit slot index SHALL advance on tick, 0->1->2->3->0.
REQ-013 A frame_end pulse SHALL assert when tick is asserted and index = 3.
REQ-014 an and seg SHALL be registered and updated every cycle from the current index, giving one cycle of latency from an index change to the outputs.
REQ-015 For the selected index i, an SHALL be all ones except an[i]=0, and seg SHALL be the decode of digit[i].
REQ-016 Decode SHALL give 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10, A=7'h08, b=7'h03, C=7'h46, d=7'h21, E=7'h06, F=7'h0E.
REQ-017 If blank[i]=1 while slot i is selected, an SHALL be 4'hF and seg SHALL be 7'h7F for that slot; scan timing SHALL be unchanged.
REQ-018 Digit and blank inputs SHALL be sampled live each cycle, with no snapshot; a change SHALL appear at the outputs on the next clock edge.
REQ-019 With blink_en=1, a blink counter SHALL count frame_end pulses; on reaching BLINK_FRAMES it SHALL clear and toggle phase.
REQ-020 When phase=0, an SHALL be 4'hF and seg SHALL be 7'h7F, overriding REQ-015 and REQ-017.
REQ-021 With blink_en=0, phase SHALL be forced to 1 and the blink counter held at 0 on the next edge; on blink_en rising, the display SHALL start in the visible phase.
REQ-022 blink_en SHALL NOT affect the prescaler or the index.
REQ-023 If frame_end and a blink_en deassertion occur in the same cycle, the deassertion SHALL win.

Reset
REQ-024 While reset is asserted: prescaler=0, index=0, blink counter=0, phase=1, an=4'hF, seg=7'h7F, dp=1.
REQ-025 Reset asserted mid-scan SHALL take effect immediately (asynchronously).
REQ-026 After reset deasserts, the first clock edge SHALL drive slot 0; tick SHALL first occur SCAN_DIV cycles after reset release.

Structure
REQ-027 The shared constants header SHALL hold the segment glyph constants, SEG_OFF=7'h7F and AN_OFF=4'hF.
REQ-028 Hex-to-segment decoding SHALL be one combinational sub-module, hex_to_seg7 (4-bit in, 7-bit active-low out).
REQ-029 The prescaler, index, blink counter and output registers SHALL live in display_scan.

Verification (SCAN_DIV=4, BLINK_FRAMES=2)
REQ-030 Scan: digits 4,3,2,1 (digit3..digit0), blank=0, blink_en=0 -> an cycles E,D,B,7, each held 4 clocks, with seg 79,24,30,19 respectively.
REQ-031 Blanking: digits 0,0,0,7, blank=4'b1110 -> slot 0 shows an=E, seg=78; slots 1-3 show an=F, seg=7F.
REQ-032 Blink: blink_en=1, digits F,E,1,d -> 2 frames (32 clocks) visible, 2 frames all-off, repeating; the visible frames show glyphs 0E,06,79,21.
REQ-033 Blink abort: deassert blink_en during the off phase -> the next clock shows the normal scan; the index sequence is unbroken.
REQ-034 Async reset: assert reset mid-slot 2 between clock edges -> outputs immediately an=F, seg=7F; after release, slot 0 for 4 cycles.
REQ-035 Live update: change digit0 from 3 to 8 while slot 0 is active -> seg changes from 30 to 00 on the next edge.
